// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 subset core: reset vector, opcode/funct/
// REGIMM encodings and the ALU operation enum.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RI_BLTZ = 5'h00;
  localparam logic [4:0] RI_BGEZ = 5'h01;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one
// clocked write port, $0 hardwired to zero. $2 is exported for observation.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] v0
);

  // Power-on contents are zero without needing a reset pulse.
  logic [31:0] regs [32] = '{default: 32'h0};

  // Register write; reset clears every entry, writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
  assign v0  = regs[2];

endmodule

// File: rtl/mips_harvard_core.sv
// Single-cycle big-endian MIPS32 subset core with separate instruction and
// data buses. Branches use a delay slot (pc / npc pair); PC == 0 halts.
module mips_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  import mips_pkg::*;

  // pc is the instruction executing now, npc the one after it (delay slot).
  logic [31:0] pc  = RESET_VECTOR;
  logic [31:0] npc = RESET_VECTOR + 32'd4;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z, rs_val, rt_val, pc_plus4, ea;
  logic [1:0]  k;
  logic        run;

  assign op    = instr_readdata[31:26];
  assign rs    = instr_readdata[25:21];
  assign rt    = instr_readdata[20:16];
  assign rd    = instr_readdata[15:11];
  assign shamt = instr_readdata[10:6];
  assign funct = instr_readdata[5:0];
  assign imm   = instr_readdata[15:0];
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_z = {16'h0, imm};

  assign active   = (pc != 32'h0);
  assign run      = clk_enable && active;
  assign pc_plus4 = pc + 32'd4;
  assign ea       = rs_val + imm_s;
  assign k        = ea[1:0];

  // Decode control
  alu_op_e     alu_op;
  logic [31:0] op_b, jump_target;
  logic [4:0]  sh, wa;
  logic        we, is_load, is_store, link, jump;

  // Decode the instruction into ALU op, operands, writeback and control flow.
  always_comb begin
    alu_op      = ALU_ADD;
    op_b        = imm_s;
    sh          = shamt;
    wa          = rt;
    we          = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    link        = 1'b0;
    jump        = 1'b0;
    jump_target = pc_plus4 + {imm_s[29:0], 2'b00};
    case (op)
      OP_SPECIAL: begin
        op_b = rt_val;
        wa   = rd;
        we   = 1'b1;
        case (funct)
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; sh = rs_val[4:0]; end
          F_SRLV: begin alu_op = ALU_SRL; sh = rs_val[4:0]; end
          F_SRAV: begin alu_op = ALU_SRA; sh = rs_val[4:0]; end
          F_JR:   begin we = 1'b0; jump = 1'b1; jump_target = rs_val; end
          F_JALR: begin link = 1'b1; jump = 1'b1; jump_target = rs_val; end
          F_ADDU: alu_op = ALU_ADD;
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          default: we = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RI_BLTZ)      jump = rs_val[31];
        else if (rt == RI_BGEZ) jump = !rs_val[31];
      end
      OP_J:    begin jump = 1'b1; jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00}; end
      OP_JAL:  begin
        jump = 1'b1; link = 1'b1; we = 1'b1; wa = 5'd31;
        jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
      end
      OP_BEQ:  jump = (rs_val == rt_val);
      OP_BNE:  jump = (rs_val != rt_val);
      OP_BLEZ: jump = rs_val[31] || (rs_val == 32'h0);
      OP_BGTZ: jump = !rs_val[31] && (rs_val != 32'h0);
      OP_ADDIU: we = 1'b1;
      OP_SLTI:  begin we = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU: begin we = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin we = 1'b1; alu_op = ALU_AND; op_b = imm_z; end
      OP_ORI:   begin we = 1'b1; alu_op = ALU_OR;  op_b = imm_z; end
      OP_XORI:  begin we = 1'b1; alu_op = ALU_XOR; op_b = imm_z; end
      OP_LUI:   begin we = 1'b1; alu_op = ALU_LUI; end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        we = 1'b1; is_load = 1'b1;
      end
      OP_SW:   is_store = 1'b1;
      default: ;
    endcase
  end

  // ALU
  logic [31:0] alu_out;
  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_out = rs_val + op_b;
      ALU_SUB:  alu_out = rs_val - op_b;
      ALU_AND:  alu_out = rs_val & op_b;
      ALU_OR:   alu_out = rs_val | op_b;
      ALU_XOR:  alu_out = rs_val ^ op_b;
      ALU_NOR:  alu_out = ~(rs_val | op_b);
      ALU_SLT:  alu_out = {31'h0, $signed(rs_val) < $signed(op_b)};
      ALU_SLTU: alu_out = {31'h0, rs_val < op_b};
      ALU_SLL:  alu_out = op_b << sh;
      ALU_SRL:  alu_out = op_b >> sh;
      ALU_SRA:  alu_out = $unsigned($signed(op_b) >>> sh);
      ALU_LUI:  alu_out = {op_b[15:0], 16'h0};
      default:  alu_out = 32'h0;
    endcase
  end

  // Big-endian load extraction; byte offset 0 lives in bits [31:24].
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  lsh, rsh;
  logic [31:0] ld_val;
  assign ld_byte = data_readdata[{~k, 3'b000} +: 8];
  assign ld_half = k[1] ? data_readdata[15:0] : data_readdata[31:16];
  assign lsh     = {k, 3'b000};
  assign rsh     = {~k, 3'b000};

  // Load result selection, including LWL/LWR merges with the old rt value.
  always_comb begin
    ld_val = data_readdata;
    case (op)
      OP_LB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_val = {24'h0, ld_byte};
      OP_LH:  ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_val = {16'h0, ld_half};
      OP_LWL: ld_val = (data_readdata << lsh) | (rt_val & ((32'h1 << lsh) - 32'h1));
      OP_LWR: ld_val = (data_readdata >> rsh) | (rt_val & ~(32'hFFFF_FFFF >> rsh));
      default: ld_val = data_readdata;
    endcase
  end

  logic [31:0] wb_val;
  assign wb_val = link ? (pc + 32'd8) : (is_load ? ld_val : alu_out);

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we && run),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wa),
    .wd    (wb_val),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .v0    (register_v0)
  );

  // Program counter pair; a taken branch redirects npc so the slot still runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      npc <= RESET_VECTOR + 32'd4;
    end else if (run) begin
      pc  <= npc;
      npc <= jump ? jump_target : npc + 32'd4;
    end
  end

  assign instr_address  = pc;
  assign data_address   = {ea[31:2], 2'b00};
  assign data_read      = is_load && active;
  assign data_write     = is_store && active;
  assign data_writedata = rt_val;

endmodule

// File: tb/tb_mips_harvard_core.sv
// Self-checking bench for mips_harvard_core: small programs in a bench-owned
// instruction ROM, a preloaded data memory model, and a queue of expected
// register_v0 values popped as instructions retire.
module tb_mips_harvard_core;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  localparam logic [5:0] SPECIAL = 6'h00, BEQ = 6'h04, BGTZ = 6'h07, JAL = 6'h03;
  localparam logic [5:0] ADDIU = 6'h09, SLTIU = 6'h0B, ORI = 6'h0D, XORI = 6'h0E, LUI = 6'h0F;
  localparam logic [5:0] LB = 6'h20, LWL = 6'h22, LW = 6'h23, LBU = 6'h24, LH = 6'h21;
  localparam logic [5:0] LHU = 6'h25, LWR = 6'h26, SW = 6'h2B;
  localparam logic [5:0] FSLL = 6'h00, FSRL = 6'h02, FSRA = 6'h03, FSRAV = 6'h07, FJR = 6'h08;
  localparam logic [5:0] FADDU = 6'h21, FSUBU = 6'h23, FNOR = 6'h27, FSLT = 6'h2A, FSLTU = 6'h2B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_enable = 1'b1;
  logic active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  int checks = 0;
  int fails = 0;

  logic [31:0] prog [64];
  logic [31:0] dmem [64];
  logic        preload_req = 1'b0;
  int          wr_count = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mips_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  // Instruction ROM: words past the loaded program read as NOP.
  logic [31:0] ioff;
  assign ioff = instr_address - RV;
  assign instr_readdata = (ioff < 32'd256) ? prog[ioff[7:2]] : 32'h0;

  // Data memory model: combinational read, enabled clocked write, preload hook.
  assign data_readdata = dmem[data_address[7:2]];
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      dmem[0] <= 32'h0000_00FF;
      dmem[1] <= 32'h5555_5555;
      dmem[2] <= 32'h0000_0001;
    end else if (data_write && clk_enable) begin
      dmem[data_address[7:2]] <= data_writedata;
      wr_count <= wr_count + 1;
      wr_addr_q.push_back(data_address);
      wr_data_q.push_back(data_writedata);
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  // One reset cycle; memory is reloaded in the same cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    preload_req = 1'b1;
    clk_enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    preload_req = 1'b0;
  endtask

  // Retire one instruction per expected entry and compare register_v0.
  task automatic drain_expected(input string name);
    logic [31:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (register_v0 !== e) begin
        fails++;
        $display("FAIL %s step %0d: register_v0 got %h expected %h", name, n, register_v0, e);
      end
      n++;
    end
  endtask

  task automatic check_halted(input string name);
    checks++;
    if (active !== 1'b0 || instr_address !== 32'h0 || data_write !== 1'b0 || data_read !== 1'b0) begin
      fails++;
      $display("FAIL %s halt: active=%b addr=%h wr=%b rd=%b expected 0/0/0/0",
               name, active, instr_address, data_write, data_read);
    end
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int n;
    n = 0;
    while (active === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL %s timeout: active got %b expected 0 within %0d cycles", name, active, budget);
    end
  endtask

  task automatic test_power_on();
    #1;
    checks++;
    if (instr_address !== RV || active !== 1'b1 || register_v0 !== 32'h0) begin
      fails++;
      $display("FAIL power_on: addr=%h active=%b v0=%h expected %h/1/0",
               instr_address, active, register_v0, RV);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (instr_address !== RV + 32'(4 * i)) begin
        fails++;
        $display("FAIL power_on_advance %0d: addr got %h expected %h", i, instr_address, RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = enc_i(LUI, 5'd0, 5'd2, 16'h1234);
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (register_v0 !== 32'h1234_0000) begin
      fails++;
      $display("FAIL reset_pre: v0 got %h expected 12340000", register_v0);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_address !== RV || register_v0 !== 32'h0 || active !== 1'b1) begin
      fails++;
      $display("FAIL reset: addr=%h v0=%h active=%b expected %h/0/1", instr_address, register_v0, active, RV);
    end
    reset = 1'b0;
  endtask

  task automatic load_lwl_prog();
    clear_prog();
    prog[0] = enc_i(LW,  5'd0, 5'd2, 16'd4);
    prog[1] = enc_i(LWL, 5'd0, 5'd2, 16'd2);
    prog[2] = enc_i(LWL, 5'd0, 5'd2, 16'd11);
    prog[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    prog[4] = enc_i(ADDIU, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic test_lwl();
    load_lwl_prog();
    do_reset();
    exp_q.push_back(32'h5555_5555);
    exp_q.push_back(32'h00FF_5555);
    exp_q.push_back(32'h01FF_5555);
    exp_q.push_back(32'h01FF_5555);
    exp_q.push_back(32'h01FF_5555);
    drain_expected("lwl");
    check_halted("lwl");
    @(negedge clk);
    checks++;
    if (register_v0 !== 32'h01FF_5555 || instr_address !== 32'h0) begin
      fails++;
      $display("FAIL lwl_hold: v0=%h addr=%h expected 01ff5555/0", register_v0, instr_address);
    end
  endtask

  task automatic test_lwr();
    clear_prog();
    prog[0] = enc_i(LUI, 5'd0, 5'd2, 16'hAAAA);
    prog[1] = enc_i(ORI, 5'd2, 5'd2, 16'hAAAA);
    prog[2] = enc_i(LWR, 5'd0, 5'd2, 16'd0);
    prog[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    do_reset();
    exp_q.push_back(32'hAAAA_0000);
    exp_q.push_back(32'hAAAA_AAAA);
    exp_q.push_back(32'hAAAA_AA00);
    exp_q.push_back(32'hAAAA_AA00);
    exp_q.push_back(32'hAAAA_AA00);
    drain_expected("lwr");
    check_halted("lwr");
  endtask

  task automatic test_sw_lw();
    int w0;
    clear_prog();
    prog[0] = enc_i(ORI, 5'd0, 5'd2, 16'h1234);
    prog[1] = enc_i(SW,  5'd0, 5'd2, 16'd16);
    prog[2] = enc_i(ADDIU, 5'd0, 5'd2, 16'd0);
    prog[3] = enc_i(LW,  5'd0, 5'd2, 16'd16);
    prog[4] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    do_reset();
    w0 = wr_count;
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    drain_expected("sw_lw");
    check_halted("sw_lw");
    checks++;
    if (wr_count - w0 != 1 || wr_addr_q.size() == 0) begin
      fails++;
      $display("FAIL sw_pulse: write cycles got %0d expected 1", wr_count - w0);
    end else begin
      checks++;
      if (wr_addr_q[$] !== 32'd16 || wr_data_q[$] !== 32'h1234) begin
        fails++;
        $display("FAIL sw_data: addr=%h data=%h expected 00000010/00001234", wr_addr_q[$], wr_data_q[$]);
      end
    end
  endtask

  task automatic test_delay_slot();
    clear_prog();
    prog[0] = enc_i(BEQ, 5'd0, 5'd0, 16'd2);
    prog[1] = enc_i(ADDIU, 5'd0, 5'd2, 16'd7);
    prog[2] = enc_i(ADDIU, 5'd0, 5'd2, 16'd99);
    prog[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    do_reset();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd7);
    drain_expected("delay_slot");
    check_halted("delay_slot");
  endtask

  task automatic test_jal();
    logic [31:0] tgt;
    tgt = RV + 32'd12;
    clear_prog();
    prog[0] = {JAL, tgt[27:2]};
    prog[1] = enc_i(ADDIU, 5'd0, 5'd2, 16'd1);
    prog[2] = enc_i(ADDIU, 5'd0, 5'd2, 16'd55);
    prog[3] = enc_r(5'd31, 5'd0, 5'd2, 5'd0, FADDU);
    prog[4] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    do_reset();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(RV + 32'd8);
    exp_q.push_back(RV + 32'd8);
    exp_q.push_back(RV + 32'd8);
    drain_expected("jal");
    check_halted("jal");
  endtask

  task automatic test_alu_loads();
    clear_prog();
    prog[0]  = enc_i(ADDIU, 5'd0, 5'd2, 16'hFFFB);
    prog[1]  = enc_i(ADDIU, 5'd0, 5'd3, 16'd3);
    prog[2]  = enc_r(5'd2, 5'd3, 5'd2, 5'd0, FSUBU);
    prog[3]  = enc_r(5'd0, 5'd2, 5'd2, 5'd1, FSRA);
    prog[4]  = enc_r(5'd0, 5'd2, 5'd2, 5'd28, FSRL);
    prog[5]  = enc_r(5'd0, 5'd2, 5'd2, 5'd4, FSLL);
    prog[6]  = enc_i(XORI, 5'd2, 5'd2, 16'hFFFF);
    prog[7]  = enc_r(5'd2, 5'd0, 5'd2, 5'd0, FNOR);
    prog[8]  = enc_r(5'd2, 5'd3, 5'd2, 5'd0, FSLT);
    prog[9]  = enc_r(5'd3, 5'd2, 5'd2, 5'd0, FSLTU);
    prog[10] = enc_i(LB,  5'd0, 5'd2, 16'd3);
    prog[11] = enc_i(LBU, 5'd0, 5'd2, 16'd3);
    prog[12] = enc_i(LH,  5'd0, 5'd2, 16'd4);
    prog[13] = enc_i(LHU, 5'd0, 5'd2, 16'd2);
    prog[14] = enc_i(SLTIU, 5'd3, 5'd2, 16'd4);
    prog[15] = enc_i(LUI, 5'd0, 5'd2, 16'h8000);
    prog[16] = enc_r(5'd3, 5'd2, 5'd2, 5'd0, FSRAV);
    prog[17] = enc_i(BGTZ, 5'd2, 5'd0, 16'd5);
    prog[18] = enc_i(ORI, 5'd2, 5'd2, 16'h00AA);
    prog[19] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FJR);
    do_reset();
    exp_q.push_back(32'hFFFF_FFFB);
    exp_q.push_back(32'hFFFF_FFFB);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_000F);
    exp_q.push_back(32'h0000_00F0);
    exp_q.push_back(32'h0000_FF0F);
    exp_q.push_back(32'hFFFF_00F0);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    exp_q.push_back(32'h0000_5555);
    exp_q.push_back(32'h0000_00FF);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'hF000_0000);
    exp_q.push_back(32'hF000_0000);
    exp_q.push_back(32'hF000_00AA);
    exp_q.push_back(32'hF000_00AA);
    exp_q.push_back(32'hF000_00AA);
    drain_expected("alu_loads");
    check_halted("alu_loads");
  endtask

  task automatic test_clk_enable();
    load_lwl_prog();
    do_reset();
    repeat (2) @(negedge clk);
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_address !== RV + 32'd8 || register_v0 !== 32'h00FF_5555) begin
        fails++;
        $display("FAIL clk_enable_freeze %0d: addr=%h v0=%h expected %h/00ff5555",
                 i, instr_address, register_v0, RV + 32'd8);
      end
    end
    clk_enable = 1'b1;
    run_to_halt("clk_enable", 20);
    checks++;
    if (register_v0 !== 32'h01FF_5555) begin
      fails++;
      $display("FAIL clk_enable_final: v0 got %h expected 01ff5555", register_v0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    test_power_on();
    test_reset();
    test_lwl();
    test_lwr();
    test_sw_lw();
    test_delay_slot();
    test_jal();
    test_alu_loads();
    test_clk_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
